// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI constants and types for the bus fabric.
//   AXI_BURST_*   : ARBURST/AWBURST encodings
//   ar_state_e    : address-channel issue FSM states
//   ar_payload_t  : AR payload layout for the default bus configuration
//                   (5-bit routed ID, 32-bit address, 4-bit len, 3-bit size)
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [0:0] {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_e;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_payload_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internally owned rotating pointer.
//   clk, rst     : clock, synchronous active-high reset (pointer -> 0)
//   req          : request vector
//   advance      : grant accepted this cycle; pointer moves past the winner
//   grant        : one-hot grant (zero when no request)
//   grant_idx    : index of the granted requester
//   grant_valid  : at least one request present
// The winner is the first requester at or after the pointer, wrapping.
module rr_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                advance,
  output logic [NUM_REQ-1:0]  grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                grant_valid
);

  logic [IDX_BITS-1:0] ptr_q, ptr_d;

  // Scan offsets from farthest to nearest so the nearest hit to the
  // pointer is the last (and therefore winning) assignment.
  always_comb begin : pick
    int idx;
    idx         = 0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[IDX_BITS'(idx)]) begin
        grant_idx   = IDX_BITS'(idx);
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      if (int'(grant_idx) == NUM_REQ - 1) ptr_d = '0;
      else                                ptr_d = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_ar_xbar.sv
// axi_ar_xbar: AXI read-address crossbar stage, NUM_M masters to NUM_S mapped
// slaves plus one default slave (index NUM_S).
//   clk, rst                 : clock, synchronous active-high reset
//   M_AR*  (packed per master): master AR channels, master i at [i*W +: W]
//   M_ARREADY                : one-hot (or zero) accept, only in IDLE
//   S_ARID                   : {master index, ARID} so R data can be routed back
//   S_ARADDR/LEN/SIZE/BURST  : shared registered payload
//   S_ARVALID                : one-hot (or zero) per slave, bit NUM_S = default
//   S_ARREADY                : per-slave ready; only the selected bit matters
// A request is accepted in IDLE, registered, and presented to one slave in
// ISSUE until that slave accepts it, giving at most one request per 2 cycles.
module axi_ar_xbar
  import axi_pkg::*;
#(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 2,
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter logic [NUM_S*ADDR_BITS-1:0] SLV_BASE  = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_S*ADDR_BITS-1:0] SLV_LIMIT = {32'h0001_FFFF, 32'h0000_FFFF},
  localparam int MIDX_BITS = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int SID_BITS  = ID_BITS + MIDX_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M*ID_BITS-1:0]   M_ARID,
  input  logic [NUM_M*ADDR_BITS-1:0] M_ARADDR,
  input  logic [NUM_M*LEN_BITS-1:0]  M_ARLEN,
  input  logic [NUM_M*SIZE_BITS-1:0] M_ARSIZE,
  input  logic [NUM_M*2-1:0]         M_ARBURST,
  input  logic [NUM_M-1:0]           M_ARVALID,
  output logic [NUM_M-1:0]           M_ARREADY,
  output logic [SID_BITS-1:0]        S_ARID,
  output logic [ADDR_BITS-1:0]       S_ARADDR,
  output logic [LEN_BITS-1:0]        S_ARLEN,
  output logic [SIZE_BITS-1:0]       S_ARSIZE,
  output logic [1:0]                 S_ARBURST,
  output logic [NUM_S:0]             S_ARVALID,
  input  logic [NUM_S:0]             S_ARREADY
);

  localparam int SEL_BITS = $clog2(NUM_S + 1);
  localparam logic [0:0] ST_IDLE  = AR_IDLE;
  localparam logic [0:0] ST_ISSUE = AR_ISSUE;

  typedef struct packed {
    logic [SID_BITS-1:0]  id;
    logic [ADDR_BITS-1:0] addr;
    logic [LEN_BITS-1:0]  len;
    logic [SIZE_BITS-1:0] size;
    logic [1:0]           burst;
  } pay_t;

  // Unpack the per-master buses.
  logic [ID_BITS-1:0]   m_id    [NUM_M];
  logic [ADDR_BITS-1:0] m_addr  [NUM_M];
  logic [LEN_BITS-1:0]  m_len   [NUM_M];
  logic [SIZE_BITS-1:0] m_size  [NUM_M];
  logic [1:0]           m_burst [NUM_M];

  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
    assign m_id[gi]    = M_ARID[gi*ID_BITS +: ID_BITS];
    assign m_addr[gi]  = M_ARADDR[gi*ADDR_BITS +: ADDR_BITS];
    assign m_len[gi]   = M_ARLEN[gi*LEN_BITS +: LEN_BITS];
    assign m_size[gi]  = M_ARSIZE[gi*SIZE_BITS +: SIZE_BITS];
    assign m_burst[gi] = M_ARBURST[gi*2 +: 2];
  end

  logic [NUM_M-1:0]     arb_grant;
  logic [MIDX_BITS-1:0] arb_idx;
  logic                 arb_valid;
  logic                 arb_advance;

  rr_arbiter #(.NUM_REQ(NUM_M)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (M_ARVALID),
    .advance     (arb_advance),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Address decode of the winning request. The select chain walks from the
  // highest slave down, so the lowest-indexed hit wins; no hit -> default.
  logic [ADDR_BITS-1:0] win_addr;
  logic [NUM_S-1:0]     hit;
  logic [SEL_BITS-1:0]  sel_chain [NUM_S+1];
  logic [SEL_BITS-1:0]  dec_sel;

  assign win_addr         = m_addr[arb_idx];
  assign sel_chain[NUM_S] = SEL_BITS'(NUM_S);

  for (genvar gi = 0; gi < NUM_S; gi++) begin : g_decode
    assign hit[gi] = (win_addr >= SLV_BASE[gi*ADDR_BITS +: ADDR_BITS]) &&
                     (win_addr <= SLV_LIMIT[gi*ADDR_BITS +: ADDR_BITS]);
    assign sel_chain[gi] = hit[gi] ? SEL_BITS'(gi) : sel_chain[gi+1];
  end

  assign dec_sel = sel_chain[0];

  // Issue FSM and payload/select registers.
  logic [0:0]          state_q, state_d;
  pay_t                pay_q, pay_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;

  always_comb begin
    state_d     = state_q;
    pay_d       = pay_q;
    sel_d       = sel_q;
    arb_advance = 1'b0;
    if (state_q == ST_IDLE) begin
      // Hold off accepting while reset is asserted so nothing is granted
      // that the reset would then discard.
      if (arb_valid && !rst) begin
        arb_advance = 1'b1;
        pay_d.id    = {arb_idx, m_id[arb_idx]};
        pay_d.addr  = win_addr;
        pay_d.len   = m_len[arb_idx];
        pay_d.size  = m_size[arb_idx];
        pay_d.burst = m_burst[arb_idx];
        sel_d       = dec_sel;
        state_d     = ST_ISSUE;
      end
    end else begin
      if (S_ARREADY[sel_q]) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pay_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
      sel_q   <= sel_d;
    end
  end

  assign M_ARREADY = arb_advance ? arb_grant : '0;

  // Driven purely from registers: no path from any ready or master valid.
  always_comb begin
    S_ARVALID = '0;
    if (state_q == ST_ISSUE) S_ARVALID[sel_q] = 1'b1;
  end

  assign S_ARID    = pay_q.id;
  assign S_ARADDR  = pay_q.addr;
  assign S_ARLEN   = pay_q.len;
  assign S_ARSIZE  = pay_q.size;
  assign S_ARBURST = pay_q.burst;

endmodule
